// File: rtl/fir_accumulator.sv
// Frame accumulator for a time-shared FIR multiplier: sums TAPS signed products,
// then rounds half-up, rescales by SHIFT and saturates into one output sample.
module fir_accumulator #(
  parameter int PROD_WIDTH = 32,
  parameter int TAPS       = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  localparam int ACC_WIDTH = PROD_WIDTH + $clog2(TAPS),
  localparam int CNT_WIDTH = ($clog2(TAPS) > 1) ? $clog2(TAPS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  input  logic signed [PROD_WIDTH-1:0] prod_data,
  output logic        [CNT_WIDTH-1:0]  tap_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_TAP = CNT_WIDTH'(TAPS - 1);

  // Limits and rounding bias live one bit wider than the accumulator so the
  // half-LSB add can never wrap.
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN =
    {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] RND_BIAS =
    ({{ACC_WIDTH{1'b0}}, 1'b1} << SHIFT) >> 1;

  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH:0]    sum_ext;
  logic signed [ACC_WIDTH:0]    biased;
  logic signed [ACC_WIDTH:0]    rounded;
  logic signed [OUT_WIDTH-1:0]  sat_data;
  logic                         sat_flag;
  logic                         accept;
  logic                         last_tap;

  assign prod_ready = (state == ACCUM);
  assign out_valid  = (state == HOLD);
  assign accept     = prod_valid && prod_ready;
  assign last_tap   = (tap_idx == LAST_TAP);

  assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
  assign sum      = acc + prod_ext;
  assign sum_ext  = {sum[ACC_WIDTH-1], sum};
  assign biased   = sum_ext + RND_BIAS;
  assign rounded  = biased >>> SHIFT;

  always_comb begin
    sat_data = rounded[OUT_WIDTH-1:0];
    sat_flag = 1'b0;
    if (rounded > OUT_MAX) begin
      sat_data = OUT_MAX[OUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end else if (rounded < OUT_MIN) begin
      sat_data = OUT_MIN[OUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end
  end

  // clear outranks both handshakes but leaves the last presented sample intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      acc      <= '0;
      tap_idx  <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (clear) begin
      state   <= ACCUM;
      acc     <= '0;
      tap_idx <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (last_tap) begin
              out_data <= sat_data;
              out_sat  <= sat_flag;
              acc      <= '0;
              tap_idx  <= '0;
              state    <= HOLD;
            end else begin
              acc     <= sum;
              tap_idx <= tap_idx + CNT_WIDTH'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/fir_accumulator.md
Name: fir_accumulator

Overview:
Downstream stage of the signed tap multiplier in the FIR datapath. It accepts one signed product per handshake and sums TAPS consecutive products into one frame. It then rounds, rescales and saturates the sum, and presents one filtered output sample through a valid/ready handshake. The tap index output drives upstream coefficient and sample selection, so a single multiplier can be time-shared across all taps.

Parameters:
PROD_WIDTH, 32, width of signed product input (2x multiplier operand width)
TAPS, 8, products per output sample; must be >= 2
OUT_WIDTH, 16, width of signed output sample
SHIFT, 15, arithmetic right shift applied to the sum (Q-format rescale); 0 allowed
(localparam) ACC_WIDTH = PROD_WIDTH + clog2(TAPS); CNT_WIDTH = max(1, clog2(TAPS))

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous frame abort
prod_valid  input  1  product available
prod_ready  output  1  block accepts product this cycle
prod_data  input  PROD_WIDTH  signed product from multiplier
tap_idx  output  CNT_WIDTH  index of next product expected (0..TAPS-1)
out_valid  output  1  output sample available
out_ready  input  1  consumer accepts sample
out_data  output  OUT_WIDTH  signed filtered sample
out_sat  output  1  out_data was clipped

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of activity in progress:
  - state=ACCUM, acc=0, tap_idx=0
  - out_valid=0, out_data=0, out_sat=0
  - prod_ready=1 on the first cycle after release
- States:
  - ACCUM: prod_ready=1, out_valid=0.
  - HOLD: prod_ready=0, out_valid=1. out_data and out_sat stay stable until the output handshake.
- ACCUM accept: on prod_valid&&prod_ready, acc <= acc + sext(prod_data) and tap_idx increments.
- Last tap: when tap_idx==TAPS-1 and a product is accepted:
  - compute S = acc + sext(prod_data) at ACC_WIDTH (no overflow possible)
  - register out_data/out_sat from S
  - clear acc and tap_idx to 0
  - go to HOLD; out_valid rises the next cycle (latency 1 cycle after last accept)
- Rounding: R = (S + 2^(SHIFT-1)) >>> SHIFT when SHIFT>0, else R = S. This is round-half-up (toward +inf). Evaluate at ACC_WIDTH+1 bits so the round-add cannot overflow.
- Saturation:
  - R > 2^(OUT_WIDTH-1)-1: out_data = max, out_sat=1.
  - R < -2^(OUT_WIDTH-1): out_data = min, out_sat=1.
  - Otherwise out_data = R[OUT_WIDTH-1:0], out_sat=0.
- HOLD exit: on out_valid&&out_ready, return to ACCUM. out_valid drops the next cycle, when prod_ready rises. No product is accepted in the handshake cycle. Minimum period is TAPS+1 cycles per output.
- Backpressure: out_ready low holds HOLD indefinitely. prod_data is ignored while prod_ready=0.
- clear (sync): has priority over all handshakes in the same cycle.
  - acc=0, tap_idx=0, state=ACCUM, out_valid=0.
  - out_data/out_sat keep their last value.
  - A pending HOLD sample is discarded.
- prod_valid gaps: partial-frame acc and tap_idx hold across any number of idle cycles.
- tap_idx is a registered output. It wraps TAPS-1 -> 0 only on last accept or clear.

Test Plan:
1. TAPS=4, SHIFT=4, OUT_WIDTH=16, products 224,0,480,195 back-to-back -> out_valid 1 cycle after 4th accept; out_data=56, out_sat=0; tap_idx sequence 0,1,2,3,0.
2. Same config, products -24,0,0,0 -> out_data=-1. Products -25,0,0,0 -> out_data=-2. Products 8,0,0,0 -> out_data=1 (round half up).
3. Same config:
   - 4x 0x40000000 -> out_data=32767, out_sat=1.
   - 4x -1000000 -> out_data=-32768, out_sat=1.
4. out_ready low 5 cycles after out_valid, prod_valid held high with new data -> prod_ready=0 throughout, out_data stable. On out_ready=1 the next frame starts and its result excludes any product presented during HOLD.
5. After 2 accepted products, pulse rst_n low mid-cycle -> outputs zero immediately. After release, frame 224,0,480,195 -> 56. Repeat the abort with clear instead of reset -> same result.
6. Random prod_valid gaps (50% duty), 20 frames of random products -> every out_data matches the reference model of rounded, saturated frame sums. No lost or duplicated products.
